// File: rtl/fp_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_pkg
// Shared types and helpers for the pipelined floating-point multiplier.
//   fp_class_e  : operand / result class (zero, normal, infinity, NaN)
//   fp_flags_t  : per-result status flags, in output order
//   bias()      : exponent bias for a given exponent width
//   inf_word()  : +Inf bit pattern, returned in a MAX_W-bit container
//   qnan_word() : canonical quiet NaN bit pattern, MAX_W-bit container
// Word width (1+EXP_W+MAN_W) must not exceed MAX_W.
// -----------------------------------------------------------------------------
package fp_mul_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef struct packed {
    logic exception;
    logic overflow;
    logic underflow;
    logic zero;
  } fp_flags_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {0, all-ones, 0}; caller takes the low W bits and sets the sign.
  function automatic logic [MAX_W-1:0] inf_word(input int exp_w, input int man_w);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
    return w;
  endfunction

  // {0, all-ones, 1 << (man_w-1)}.
  function automatic logic [MAX_W-1:0] qnan_word(input int exp_w, input int man_w);
    logic [MAX_W-1:0] w;
    w = inf_word(exp_w, man_w);
    w[man_w - 1] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/fp_mul_unpack.sv
// -----------------------------------------------------------------------------
// fp_unpack
// Splits one operand into fields and classifies it. Subnormals (exp == 0)
// are flushed to zero with their sign kept; the significand carries the
// hidden bit for normal operands and is zero otherwise.
// Ports:
//   x     in  W        operand {sign, exp, man}
//   sign  out 1        sign bit
//   expo  out EXP_W    biased exponent field as stored
//   sig   out MAN_W+1  {hidden bit, man} for normals, 0 for other classes
//   cls   out 2        fp_class_e
// -----------------------------------------------------------------------------
module fp_unpack
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0]     x,
  output logic             sign,
  output logic [EXP_W-1:0] expo,
  output logic [MAN_W:0]   sig,
  output fp_class_e        cls
);

  logic [MAN_W-1:0] man;

  assign sign = x[W-1];
  assign expo = x[W-2 -: EXP_W];
  assign man  = x[MAN_W-1:0];

  // NOTE: every output of a combinational block gets a default first, so
  // no path through the if-chain can leave one unassigned and infer a latch.
  always_comb begin
    cls = FP_NORM;
    sig = {1'b1, man};
    if (expo == '0) begin
      cls = FP_ZERO;
      sig = '0;
    end else if (&expo) begin
      cls = (man != '0) ? FP_NAN : FP_INF;
      sig = '0;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe
// Three-stage pipelined floating-point multiplier with valid/ready on both
// sides. Parametrised exponent/mantissa widths, flush-to-zero on subnormal
// inputs, no subnormal outputs.
//   S1: unpack both operands, classify the result, add exponents, multiply
//       significands.
//   S2: normalise the product and round (or truncate).
//   S3: pack the result and flags into the output registers.
// out_valid rises on the third rising edge counting the accept edge as the
// first. One global advance signal moves all stages together; bubbles move
// but are not squeezed out, so a full pipe holds three results.
//
// Build option: define FP_MUL_RNE_EN for round-to-nearest-even; otherwise
// the mantissa is truncated. Only S2 differs between the two builds.
//
// Ports:
//   clk        in  1   rising-edge clock
//   rst_n      in  1   synchronous active-low reset
//   in_valid   in  1   operand pair valid
//   in_ready   out 1   operands accepted this cycle (depends on out_ready only)
//   a, b       in  W   operands {sign, exp, man}
//   out_valid  out 1   result valid
//   out_ready  in  1   consumer takes the result
//   prod       out W   product
//   exception  out 1   an operand was Inf or NaN
//   overflow   out 1   finite result exceeded the largest exponent
//   underflow  out 1   nonzero result fell below the smallest normal
//   zero       out 1   result is +/-0
// -----------------------------------------------------------------------------
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] prod,
  output logic         exception,
  output logic         overflow,
  output logic         underflow,
  output logic         zero
);

  // Exponent arithmetic is two bits wider than the field so that neither the
  // sum of two large exponents nor the bias subtraction can wrap.
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS_S = EW'(bias(EXP_W));
  localparam logic signed [EW-1:0] MAX_E  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E = '0;

  localparam logic [MAX_W-1:0] INF_FULL  = inf_word(EXP_W, MAN_W);
  localparam logic [MAX_W-1:0] QNAN_FULL = qnan_word(EXP_W, MAN_W);
  localparam logic [W-1:0]     INF_POS   = INF_FULL[W-1:0];
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

  // Global advance: every stage moves when the output slot is free or is
  // being drained this cycle.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- S1 ----
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   siga, sigb;
  fp_class_e        ca, cb;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x    (a),
    .sign (sa),
    .expo (ea),
    .sig  (siga),
    .cls  (ca)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x    (b),
    .sign (sb),
    .expo (eb),
    .sig  (sigb),
    .cls  (cb)
  );

  fp_class_e              s1_cls_d;
  logic signed [EW-1:0]   s1_exp_d;
  logic        [PW-1:0]   s1_prod_d;

  // Result class in priority order: NaN (including Inf x 0), Inf, zero.
  always_comb begin
    s1_cls_d = FP_NORM;
    if (ca == FP_NAN || cb == FP_NAN ||
        (ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF))
      s1_cls_d = FP_NAN;
    else if (ca == FP_INF || cb == FP_INF)
      s1_cls_d = FP_INF;
    else if (ca == FP_ZERO || cb == FP_ZERO)
      s1_cls_d = FP_ZERO;
  end

  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
  assign s1_prod_d = {{(MAN_W+1){1'b0}}, siga} * {{(MAN_W+1){1'b0}}, sigb};

  logic                 s1_valid;
  logic                 s1_sign;
  fp_class_e            s1_cls;
  logic signed [EW-1:0] s1_exp;
  logic        [PW-1:0] s1_prod;

  // ---------------------------------------------------------------- S2 ----
  // The product of two [1,2) significands lies in [1,4). With the MSB set it
  // is already normalised (exponent +1); otherwise shift left by one. The
  // shifted value drops the MSB, which is the hidden bit either way.
  logic [PW-2:0]        s2_shift;
  logic [MAN_W-1:0]     s2_man_t;
  logic signed [EW-1:0] s2_exp_n;
  logic                 rnd_g, rnd_s;
  logic [MAN_W-1:0]     s2_man_d;
  logic signed [EW-1:0] s2_exp_d;

  always_comb begin
    s2_shift = s1_prod[PW-1] ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
    s2_man_t = s2_shift[PW-2 -: MAN_W];
    s2_exp_n = s1_exp + (s1_prod[PW-1] ? ONE_E : ZERO_E);
  end

  assign rnd_g = s2_shift[MAN_W];
  assign rnd_s = |s2_shift[MAN_W-1:0];

`ifdef FP_MUL_RNE_EN
  logic           rnd_up;
  logic [MAN_W:0] man_sum;

  // Round up on G & (S | lsb). A carry out of the mantissa leaves it at
  // zero (1.111.. + ulp = 10.000..) and bumps the exponent.
  always_comb begin
    rnd_up   = rnd_g & (rnd_s | s2_man_t[0]);
    man_sum  = {1'b0, s2_man_t} + {{MAN_W{1'b0}}, rnd_up};
    s2_man_d = man_sum[MAN_W-1:0];
    s2_exp_d = s2_exp_n + (man_sum[MAN_W] ? ONE_E : ZERO_E);
  end
`else
  // Truncation: guard and sticky are intentionally discarded.
  logic unused_round_bits;
  assign unused_round_bits = rnd_g ^ rnd_s;
  assign s2_man_d          = s2_man_t;
  assign s2_exp_d          = s2_exp_n;
`endif

  logic                 s2_valid;
  logic                 s2_sign;
  fp_class_e            s2_cls;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_man;

  // ---------------------------------------------------------------- S3 ----
  logic [W-1:0] prod_d;
  fp_flags_t    flags_d;

  always_comb begin
    prod_d  = '0;
    flags_d = '0;
    case (s2_cls)
      FP_NAN: begin
        prod_d            = QNAN;
        flags_d.exception = 1'b1;
      end
      FP_INF: begin
        prod_d            = INF_POS;
        prod_d[W-1]       = s2_sign;
        flags_d.exception = 1'b1;
      end
      FP_ZERO: begin
        prod_d[W-1]  = s2_sign;
        flags_d.zero = 1'b1;
      end
      default: begin
        if (s2_exp >= MAX_E) begin
          prod_d           = INF_POS;
          prod_d[W-1]      = s2_sign;
          flags_d.overflow = 1'b1;
        end else if (s2_exp <= ZERO_E) begin
          prod_d[W-1]       = s2_sign;
          flags_d.underflow = 1'b1;
          flags_d.zero      = 1'b1;
        end else begin
          prod_d = {s2_sign, s2_exp[EXP_W-1:0], s2_man};
        end
      end
    endcase
  end

  // ------------------------------------------------------------ registers --
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage-to-stage order does not matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      prod      <= '0;
      exception <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      prod      <= prod_d;
      exception <= flags_d.exception;
      overflow  <= flags_d.overflow;
      underflow <= flags_d.underflow;
      zero      <= flags_d.zero;
    end
  end

  // NOTE: internal datapath registers have no reset; their contents are only
  // observed behind a valid bit, so resetting them would just add fan-out.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= sa ^ sb;
      s1_cls  <= s1_cls_d;
      s1_exp  <= s1_exp_d;
      s1_prod <= s1_prod_d;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_exp  <= s2_exp_d;
      s2_man  <= s2_man_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_pipe
// Scoreboard bench for fp_mul_pipe (single precision). The driver pushes the
// hand-computed expected result when a transfer is accepted; an independent
// monitor pops and compares whenever a result leaves the DUT, and also checks
// that a stalled output holds steady.
// -----------------------------------------------------------------------------
module tb_fp_mul_pipe;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] prod;
  logic         exception, overflow, underflow, zero;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .exception (exception),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] p;
    logic [3:0]  f;    // {exception, overflow, underflow, zero}
    int          acc;  // edge number of the accepting edge
    bit          lat;  // check latency for this item
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   out_count = 0;
  bit   stall_seen = 1'b0;

`ifdef FP_MUL_RNE_EN
  localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
  localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with in_valid low.
  task automatic send(input string name, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] p, input logic [3:0] f, input bit lat);
    bit ok;
    int budget;
    exp_t e;
    ok = 1'b0;
    budget = 0;
    a = va;
    b = vb;
    in_valid = 1'b1;
    while (!ok) begin
      #1;
      ok = in_ready;
      e.acc = edge_cnt + 1;
      @(posedge clk);
      if (ok) begin
        e.name = name;
        e.p    = p;
        e.f    = f;
        e.lat  = lat;
        sb_q.push_back(e);
      end else begin
        stall_seen = 1'b1;
        budget++;
        if (budget > 200) begin
          checks++;
          errors++;
          $display("FAIL %s: in_ready stuck low, required accept within 200 cycles", name);
          ok = 1'b1;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({name, " drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: samples between edges, after the driver has settled.
  initial begin
    exp_t        e;
    bit          held;
    logic [31:0] held_p;
    logic [3:0]  held_f;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (held) begin
          check("hold prod", prod, held_p);
          check("hold flags", 32'({exception, overflow, underflow, zero}), 32'(held_f));
        end
        if (out_ready) begin
          held = 1'b0;
          out_count++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected output: got %h, required no output", prod);
          end else begin
            e = sb_q.pop_front();
            check({e.name, " prod"}, prod, e.p);
            check({e.name, " flags"}, 32'({exception, overflow, underflow, zero}), 32'(e.f));
            if (e.lat) check({e.name, " latency"}, 32'(edge_cnt - e.acc + 1), 32'd3);
          end
        end else begin
          held   = 1'b1;
          held_p = prod;
          held_f = {exception, overflow, underflow, zero};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] va, vb, p;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[$];
  vec_t bp_vecs[$];

  initial begin
    int cnt;
    vecs = '{
      '{"2x3",        32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000},
      '{"ovf",        32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100},
      '{"unf",        32'h00800000, 32'h00800000, 32'h00000000, 4'b0011},
      '{"inf*0",      32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
      '{"-inf*2",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'b1000},
      '{"-0*1",       32'h80000000, 32'h3F800000, 32'h80000000, 4'b0001},
      '{"tie",        32'h3F800001, 32'h3FC00000, TIE_RES,      4'b0000},
      '{"1.5sq",      32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000},
      '{"-2*0.5",     32'hC0000000, 32'h3F000000, 32'hBF800000, 4'b0000},
      '{"nan",        32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000},
      '{"sub flush",  32'h80000001, 32'h3F800000, 32'h80000000, 4'b0001},
      '{"max finite", 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000},
      '{"ovf edge",   32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100},
      '{"unf edge",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011},
      '{"min normal", 32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000},
      '{"ulp sq",     32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000}
    };
    bp_vecs = '{
      '{"bp0", 32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000},
      '{"bp1", 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000},
      '{"bp2", 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000},
      '{"bp3", 32'h40000000, 32'h40800000, 32'h41000000, 4'b0000},
      '{"bp4", 32'h40000000, 32'h40A00000, 32'h41200000, 4'b0000},
      '{"bp5", 32'h40000000, 32'h40C00000, 32'h41400000, 4'b0000}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset prod", prod, 32'd0);
    check("reset flags", 32'({exception, overflow, underflow, zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready after release", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed vectors, back to back, no backpressure.
    foreach (vecs[i])
      send(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].p, vecs[i].f, i == 0);
    drain("directed");

    // Backpressure: six back-to-back operands, output blocked for 5 cycles.
    out_count  = 0;
    stall_seen = 1'b0;
    out_ready  = 1'b0;
    fork
      begin
        foreach (bp_vecs[i])
          send(bp_vecs[i].name, bp_vecs[i].va, bp_vecs[i].vb, bp_vecs[i].p, bp_vecs[i].f, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("backpressure");
    check("backpressure stall seen", 32'(stall_seen), 32'd1);
    check("backpressure output count", 32'(out_count), 32'd6);

    // Reset with three results in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(bp_vecs[i].name, bp_vecs[i].va, bp_vecs[i].vb, bp_vecs[i].p, bp_vecs[i].f, 1'b0);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset prod", prod, 32'd0);
    check("mid reset flags", 32'({exception, overflow, underflow, zero}), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check("no stale results", 32'(cnt), 32'd0);
    @(negedge clk);
    send("after reset 3x3", 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 1'b0);
    drain("after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
